manchester_decode: RTL

Recovers the data bits of the Manchester-coded thermostat link from the raw line input and presents them to the frame decoder (`serial_decode`) as a data bit plus a one-cycle valid strobe. It sits between the input pin and the frame decoder. It synchronises and edge-detects the line itself, learns the half-bit period from the preamble, and resolves bit phase. It also signals end-of-frame on line silence and error on malformed timing.

---
 rtl/manchester_decode.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/manchester_decode.sv
// manchester_decode
//   Recovers data bits from a Manchester-coded line. The raw line is
//   synchronised and edge-detected, the half-bit period is learned from the
//   preamble, and bit phase is resolved from long (full-bit) intervals.
//
// Ports
//   clock        sole clock, rising edge
//   reset_n      synchronous active-low reset
//   digital_in   raw asynchronous line input
//   bit_data     decoded bit, meaningful while bit_valid is high (held otherwise)
//   bit_valid    one-cycle strobe per decoded bit
//   locked       high while the half-bit period is locked
//   frame_end    one-cycle pulse when the line goes silent while locked
//   error        one-cycle pulse on a glitch or a phase violation
//   half_period  learned half-bit interval in cycles, 0 when not locked
module manchester_decode #(
    parameter int CNT_WIDTH   = 12,
    parameter int MIN_HALF    = 4,
    parameter int TRAIN_EDGES = 8
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 digital_in,
    output logic                 bit_data,
    output logic                 bit_valid,
    output logic                 locked,
    output logic                 frame_end,
    output logic                 error,
    output logic [CNT_WIDTH-1:0] half_period
);

    localparam int TW = CNT_WIDTH + 2;
    localparam int MW = $clog2(TRAIN_EDGES + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_TRAIN  = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;
    localparam logic [TW-1:0]        MIN_T      = TW'(MIN_HALF);
    localparam logic [MW-1:0]        MATCH_DONE = MW'(TRAIN_EDGES);

    logic                 sync1_reg, sync2_reg, prev_reg;
    logic [1:0]           state_reg, state_next;
    logic [CNT_WIDTH-1:0] cnt_reg, cnt_next;
    logic [CNT_WIDTH-1:0] h_reg, h_next;
    logic [MW-1:0]        match_reg, match_next;
    logic                 phase_known_reg, phase_known_next;
    logic                 at_mid_reg, at_mid_next;
    logic                 bit_data_reg, bit_data_next;
    logic                 bit_valid_reg, bit_valid_next;
    logic                 locked_reg, locked_next;
    logic                 frame_end_reg, frame_end_next;
    logic                 error_reg, error_next;
    logic [CNT_WIDTH-1:0] half_period_reg, half_period_next;

    logic          edge_det;
    logic [TW-1:0] h_ext, cnt_ext, lo, mid, hi, tol, diff;
    logic          in_tol;

    assign edge_det = sync2_reg ^ prev_reg;

    // Thresholds are widened by two bits so 2h + h/2 cannot overflow.
    assign h_ext   = {2'b00, h_reg};
    assign cnt_ext = {2'b00, cnt_reg};
    assign lo      = h_ext >> 1;
    assign mid     = h_ext + (h_ext >> 1);
    assign hi      = (h_ext << 1) + (h_ext >> 1);
    assign tol     = h_ext >> 2;
    assign diff    = (cnt_ext >= h_ext) ? (cnt_ext - h_ext) : (h_ext - cnt_ext);
    assign in_tol  = (diff <= tol);

    always_comb begin
        state_next       = state_reg;
        h_next           = h_reg;
        match_next       = match_reg;
        phase_known_next = phase_known_reg;
        at_mid_next      = at_mid_reg;
        bit_data_next    = bit_data_reg;
        bit_valid_next   = 1'b0;
        locked_next      = locked_reg;
        frame_end_next   = 1'b0;
        error_next       = 1'b0;
        half_period_next = half_period_reg;

        // cnt_reg equals the interval length in the cycle an edge is seen.
        if (edge_det) begin
            cnt_next = CNT_WIDTH'(1);
        end else if (cnt_reg != CNT_MAX) begin
            cnt_next = cnt_reg + 1'b1;
        end else begin
            cnt_next = cnt_reg;
        end

        case (state_reg)
            ST_IDLE: begin
                if (edge_det) begin
                    state_next = ST_TRAIN;
                    match_next = '0;
                end
            end

            ST_TRAIN: begin
                if (edge_det) begin
                    // match_reg == 0 means no half-period has been taken yet.
                    if (match_reg == '0 || !in_tol) begin
                        if (cnt_ext < MIN_T) begin
                            match_next = '0;
                        end else begin
                            h_next     = cnt_reg;
                            match_next = MW'(1);
                        end
                    end else begin
                        match_next = match_reg + 1'b1;
                    end
                    if (match_next == MATCH_DONE) begin
                        state_next       = ST_LOCKED;
                        locked_next      = 1'b1;
                        half_period_next = h_next;
                        phase_known_next = 1'b0;
                        at_mid_next      = 1'b0;
                    end
                end else if ((match_reg == '0) ? (cnt_reg == CNT_MAX)
                                               : (cnt_ext > h_ext + tol)) begin
                    state_next = ST_IDLE;
                    match_next = '0;
                end
            end

            ST_LOCKED: begin
                // Silence beats a coincident edge; that edge restarts training.
                if (cnt_ext >= hi || cnt_reg == CNT_MAX) begin
                    frame_end_next   = 1'b1;
                    locked_next      = 1'b0;
                    half_period_next = '0;
                    match_next       = '0;
                    state_next       = edge_det ? ST_TRAIN : ST_IDLE;
                end else if (edge_det) begin
                    if (cnt_ext < lo) begin
                        error_next       = 1'b1;
                        locked_next      = 1'b0;
                        half_period_next = '0;
                        match_next       = '0;
                        state_next       = ST_IDLE;
                    end else if (cnt_ext < mid) begin
                        // Short interval: toggles between boundary and mid-bit
                        // once phase is known; meaningless before that.
                        if (phase_known_reg) begin
                            if (at_mid_reg) begin
                                at_mid_next = 1'b0;
                            end else begin
                                at_mid_next    = 1'b1;
                                bit_valid_next = 1'b1;
                                bit_data_next  = sync2_reg;
                            end
                        end
                    end else if (!phase_known_reg || at_mid_reg) begin
                        // A full-bit interval can only end on a mid-bit edge.
                        phase_known_next = 1'b1;
                        at_mid_next      = 1'b1;
                        bit_valid_next   = 1'b1;
                        bit_data_next    = sync2_reg;
                    end else begin
                        error_next       = 1'b1;
                        locked_next      = 1'b0;
                        half_period_next = '0;
                        match_next       = '0;
                        state_next       = ST_IDLE;
                    end
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sync1_reg       <= 1'b0;
            sync2_reg       <= 1'b0;
            prev_reg        <= 1'b0;
            state_reg       <= ST_IDLE;
            cnt_reg         <= '0;
            h_reg           <= '0;
            match_reg       <= '0;
            phase_known_reg <= 1'b0;
            at_mid_reg      <= 1'b0;
            bit_data_reg    <= 1'b0;
            bit_valid_reg   <= 1'b0;
            locked_reg      <= 1'b0;
            frame_end_reg   <= 1'b0;
            error_reg       <= 1'b0;
            half_period_reg <= '0;
        end else begin
            sync1_reg       <= digital_in;
            sync2_reg       <= sync1_reg;
            prev_reg        <= sync2_reg;
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            h_reg           <= h_next;
            match_reg       <= match_next;
            phase_known_reg <= phase_known_next;
            at_mid_reg      <= at_mid_next;
            bit_data_reg    <= bit_data_next;
            bit_valid_reg   <= bit_valid_next;
            locked_reg      <= locked_next;
            frame_end_reg   <= frame_end_next;
            error_reg       <= error_next;
            half_period_reg <= half_period_next;
        end
    end

    assign bit_data    = bit_data_reg;
    assign bit_valid   = bit_valid_reg;
    assign locked      = locked_reg;
    assign frame_end   = frame_end_reg;
    assign error       = error_reg;
    assign half_period = half_period_reg;

endmodule
